// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit.
// Holds the architectural PC and keeps exactly one instruction in flight:
// it requests the instruction from imem, hands it to decode with pc/snpc,
// then waits for writeback to return the next PC (dnpc) before fetching again.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request (addr == pc)
//   imem_rsp_valid/ready/data/err    fetch response; err qualified by valid
//   inst_valid/ready, inst, pc, snpc instruction to decode (snpc = pc + 4)
//   wb_valid, wb_dnpc                next PC from writeback
//   fetch_fault                      sticky fault flag (bus error or misaligned dnpc)
//
// Optional build macro YSYX_25020047_IFU_PERF_EN adds perf_fetch_cnt and
// perf_stall_cnt (64-bit, wrapping). Functional behaviour is identical without it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | single dead cycle after reset release
// REQ   | request for pc presented to imem, held until accepted
// WAIT  | waiting for the response; data latched into inst on success
// DISP  | inst/pc/snpc offered to decode, held until accepted
// EXEC  | instruction executing; waiting for writeback's dnpc
// FAULT | bus error or misaligned dnpc seen; only reset leaves
module ysyx_25020047_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] snpc,
   input  logic        wb_valid,
   input  logic [31:0] wb_dnpc,
   output logic        fetch_fault
`ifdef YSYX_25020047_IFU_PERF_EN
   ,
   output logic [63:0] perf_fetch_cnt,
   output logic [63:0] perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DISP  = 3'd3,
      S_EXEC  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        rsp_ok;
   logic        wb_ok;

   assign rsp_ok = (state == S_WAIT) && imem_rsp_valid && !imem_rsp_err;
   assign wb_ok  = (state == S_EXEC) && wb_valid && (wb_dnpc[1:0] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pc_q   <= RESET_PC;
         inst_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (rsp_ok) inst_q <= imem_rsp_data;
         if (wb_ok)  pc_q   <= wb_dnpc;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ:  if (imem_req_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            // error takes priority over data in the same response
            if (imem_rsp_valid) state_nxt = imem_rsp_err ? S_FAULT : S_DISP;
         end
         S_DISP: if (inst_ready) state_nxt = S_EXEC;
         S_EXEC: begin
            if (wb_valid) state_nxt = (wb_dnpc[1:0] == 2'b00) ? S_REQ : S_FAULT;
         end
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_FAULT;
      endcase
   end

   // Outputs depend on registered state only; no input-to-output paths.
   always_comb begin
      imem_req_valid = 1'b0;
      imem_rsp_ready = 1'b0;
      inst_valid     = 1'b0;
      fetch_fault    = 1'b0;
      case (state)
         S_REQ:   imem_req_valid = 1'b1;
         S_WAIT:  imem_rsp_ready = 1'b1;
         S_DISP:  inst_valid     = 1'b1;
         S_FAULT: fetch_fault    = 1'b1;
         default: ;
      endcase
   end

   assign imem_req_addr = pc_q;
   assign pc            = pc_q;
   assign snpc          = pc_q + 32'd4;
   assign inst          = inst_q;

`ifdef YSYX_25020047_IFU_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= 64'h0;
         perf_stall_cnt <= 64'h0;
      end else begin
         if (rsp_ok) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (((state == S_REQ) && !imem_req_ready) ||
             ((state == S_WAIT) && !imem_rsp_valid))
            perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
module tb_ysyx_25020047_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] snpc;
   logic        wb_valid;
   logic [31:0] wb_dnpc;
   logic        fetch_fault;
`ifdef YSYX_25020047_IFU_PERF_EN
   logic [63:0] perf_fetch_cnt;
   logic [63:0] perf_stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   ysyx_25020047_ifu #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .pc             (pc),
      .snpc           (snpc),
      .wb_valid       (wb_valid),
      .wb_dnpc        (wb_dnpc),
      .fetch_fault    (fetch_fault)
`ifdef YSYX_25020047_IFU_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          req_wait;
      int          rsp_wait;
      int          disp_wait;
      bit          noise;
      logic [31:0] data;
      logic [31:0] dnpc;
      logic [31:0] exp_pc;
      logic [31:0] exp_snpc;
   } fetch_vec_t;

   fetch_vec_t vec[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Random values on inputs that the current phase must ignore.
   task automatic noise_inputs(input bit en, input bit rsp, input bit ird, input bit wb);
      if (en && rsp) begin
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_err   = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom();
      end
      if (en && ird) inst_ready = 1'($urandom_range(0, 1));
      if (en && wb) begin
         wb_valid = 1'($urandom_range(0, 1));
         wb_dnpc  = $urandom();
      end
   endtask

   task automatic quiet_inputs();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      inst_ready     = 1'b0;
      wb_valid       = 1'b0;
   endtask

   // One complete fetch transaction; entered with the DUT in REQ.
   task automatic do_fetch(input fetch_vec_t v);
      logic [31:0] hold_inst, hold_pc, hold_snpc;
`ifdef YSYX_25020047_IFU_PERF_EN
      logic [63:0] stall0, fetch0;
      stall0 = perf_stall_cnt;
      fetch0 = perf_fetch_cnt;
`endif
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, v.exp_pc);
      for (int i = 0; i < v.req_wait; i++) begin
         quiet_inputs();
         noise_inputs(v.noise, 1, 1, 1);
         tick();
         chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
         chk("req_hold_addr", imem_req_addr, v.exp_pc);
      end
      quiet_inputs();
      noise_inputs(v.noise, 1, 1, 1);
      imem_req_ready = 1'b1;
      tick();
      quiet_inputs();
      chk("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
      for (int i = 0; i < v.rsp_wait; i++) begin
         quiet_inputs();
         noise_inputs(v.noise, 0, 1, 1);
         tick();
         chk("wait_inst_valid", 32'(inst_valid), 32'd0);
      end
      quiet_inputs();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = v.data;
      tick();
      quiet_inputs();
      chk("disp_inst_valid", 32'(inst_valid), 32'd1);
      chk("disp_inst", inst, v.data);
      chk("disp_pc", pc, v.exp_pc);
      chk("disp_snpc", snpc, v.exp_snpc);
      hold_inst = inst;
      hold_pc   = pc;
      hold_snpc = snpc;
      for (int i = 0; i < v.disp_wait; i++) begin
         quiet_inputs();
         noise_inputs(v.noise, 1, 0, 1);
         tick();
         chk("disp_hold_valid", 32'(inst_valid), 32'd1);
         chk("disp_hold_inst", inst, hold_inst);
         chk("disp_hold_pc", pc, hold_pc);
         chk("disp_hold_snpc", snpc, hold_snpc);
      end
      // wb_valid may coincide with the DISP->EXEC edge and must be ignored
      quiet_inputs();
      noise_inputs(v.noise, 1, 0, 1);
      inst_ready = 1'b1;
      tick();
      quiet_inputs();
      chk("exec_inst_valid", 32'(inst_valid), 32'd0);
      chk("exec_req_valid", 32'(imem_req_valid), 32'd0);
      if (v.noise) begin
         repeat ($urandom_range(0, 2)) begin
            quiet_inputs();
            noise_inputs(1, 1, 1, 0);
            tick();
            chk("exec_idle_req", 32'(imem_req_valid), 32'd0);
            chk("exec_pc", pc, v.exp_pc);
         end
      end
      quiet_inputs();
      wb_valid = 1'b1;
      wb_dnpc  = v.dnpc;
      tick();
      quiet_inputs();
      chk("wb_next_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wb_next_req_addr", imem_req_addr, v.dnpc);
`ifdef YSYX_25020047_IFU_PERF_EN
      chk("perf_stall", 32'(perf_stall_cnt - stall0), 32'(v.req_wait + v.rsp_wait));
      chk("perf_fetch", 32'(perf_fetch_cnt - fetch0), 32'd1);
`endif
   endtask

   // Zero-wait request/response/dispatch, leaving the DUT in EXEC.
   task automatic run_to_exec(input logic [31:0] data);
      quiet_inputs();
      imem_req_ready = 1'b1;
      tick();
      quiet_inputs();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      quiet_inputs();
      inst_ready = 1'b1;
      tick();
      quiet_inputs();
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst_n = 1'b0;
      #2;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_snpc", snpc, RST_PC + 32'd4);
      chk("rst_inst", inst, 32'h0);
      tick();
      rst_n = 1'b1;
      chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RST_PC);
   endtask

   initial begin
      logic [31:0] model_pc;
      fetch_vec_t  rv;

      vec[0] = '{0, 0, 0, 1'b0, 32'h0010_0093, 32'h8000_0100, 32'h8000_0000, 32'h8000_0004};
      vec[1] = '{3, 1, 0, 1'b0, 32'h0020_0113, 32'hFFFF_FFFC, 32'h8000_0100, 32'h8000_0104};
      vec[2] = '{0, 2, 1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
      vec[3] = '{1, 0, 5, 1'b1, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 32'h0000_0004};

      rst_n         = 1'b0;
      imem_rsp_data = 32'h0;
      wb_dnpc       = 32'h0;
      quiet_inputs();
      tick();
      do_reset();

      for (int i = 0; i < 4; i++) do_fetch(vec[i]);

      // Random transactions against a PC-sequence model: each fetch comes
      // from the previous dnpc, snpc is that address plus four.
      model_pc = vec[3].dnpc;
      for (int n = 0; n < 25; n++) begin
         rv.req_wait  = $urandom_range(0, 3);
         rv.rsp_wait  = $urandom_range(0, 3);
         rv.disp_wait = $urandom_range(0, 3);
         rv.noise     = 1'b1;
         rv.data      = $urandom();
         rv.dnpc      = $urandom() & 32'hFFFF_FFFC;
         rv.exp_pc    = model_pc;
         rv.exp_snpc  = model_pc + 32'd4;
         do_fetch(rv);
         model_pc = rv.dnpc;
      end

      // Bus error: error wins over data, fault is sticky.
      quiet_inputs();
      imem_req_ready = 1'b1;
      tick();
      quiet_inputs();
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = 1'b1;
      imem_rsp_data  = 32'h0000_0013;
      tick();
      for (int i = 0; i < 5; i++) begin
         imem_req_ready = 1'b1;
         noise_inputs(1, 1, 1, 1);
         chk("err_fault", 32'(fetch_fault), 32'd1);
         chk("err_req_valid", 32'(imem_req_valid), 32'd0);
         chk("err_inst_valid", 32'(inst_valid), 32'd0);
         chk("err_rsp_ready", 32'(imem_rsp_ready), 32'd0);
         tick();
      end
      do_reset();

      // Misaligned dnpc: fault and pc untouched.
      rv = '{0, 0, 0, 1'b0, 32'h0000_0513, 32'h8000_0040, RST_PC, RST_PC + 32'd4};
      do_fetch(rv);
      run_to_exec(32'h0000_0593);
      wb_valid = 1'b1;
      wb_dnpc  = 32'h8000_0002;
      tick();
      quiet_inputs();
      chk("misal_fault", 32'(fetch_fault), 32'd1);
      chk("misal_pc", pc, 32'h8000_0040);
      chk("misal_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      chk("misal_sticky", 32'(fetch_fault), 32'd1);
      do_reset();

      // Reset in WAIT, then a stale response during IDLE/REQ.
      imem_req_ready = 1'b1;
      tick();
      quiet_inputs();
      chk("midrst_in_wait", 32'(imem_rsp_ready), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("midrst_pc", pc, RST_PC);
      chk("midrst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      tick();
      rst_n          = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         chk("stale_inst_valid", 32'(inst_valid), 32'd0);
         chk("stale_rsp_ready", 32'(imem_rsp_ready), 32'd0);
         tick();
      end
      quiet_inputs();
      chk("stale_inst", inst, 32'h0);
      rv = '{0, 0, 0, 1'b0, 32'h0010_0093, 32'h8000_0008, RST_PC, RST_PC + 32'd4};
      do_fetch(rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget, required completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
